// File: rtl/noc_pkg.sv
// Shared sub-network definitions: flit layout, direction codes and sizing helpers.
package noc_pkg;

   localparam int DATASIZE = 40;

   localparam int SRC_MSB  = 39;
   localparam int SRC_LSB  = 36;
   localparam int DST_MSB  = 35;
   localparam int DST_LSB  = 32;
   localparam int TS_MSB   = 31;
   localparam int TS_LSB   = 24;
   localparam int DATA_MSB = 23;
   localparam int DATA_LSB = 2;
   localparam int TYPE_MSB = 1;
   localparam int TYPE_LSB = 0;

   typedef enum logic [3:0] {
      DIR_LOCAL = 4'b0000,
      DIR_E     = 4'b0010,
      DIR_N     = 4'b0100,
      DIR_NONE  = 4'b1111
   } dir_e;

   typedef struct packed {
      logic [SRC_MSB-SRC_LSB:0]   src;
      logic [DST_MSB-DST_LSB:0]   dst;
      logic [TS_MSB-TS_LSB:0]     ts;
      logic [DATA_MSB-DATA_LSB:0] data;
      logic [TYPE_MSB-TYPE_LSB:0] typ;
   } flit_t;

   // Pressure must represent 0..DEPTH inclusive, hence one bit more than a pointer.
   function automatic int pressure_w(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/ib_sub.sv
// Router input buffer: DEPTH-entry FIFO with registered-only ready/valid and
// an occupancy (pressure) export for adaptive routing in neighbouring routers.
module ib_sub
   import noc_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = noc_pkg::DATASIZE
) (
   input  logic                ib_clk,
   input  logic                rst_n,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic [DATASIZE-1:0] data_out,
   output logic                valid_out,
   input  logic                rc_ready,
   output logic [WIDTH:0]      pressure_out,
   output logic                ovf_err
);

   localparam int             PW   = pressure_w(WIDTH);
   localparam logic [PW-1:0]  FULL = PW'(DEPTH);

   logic [DATASIZE-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0]    r_wr_ptr;
   logic [WIDTH-1:0]    r_rd_ptr;
   logic [PW-1:0]       r_count;
   logic                r_ovf;

   logic                w_push;
   logic                w_pop;

   // Handshake flags come from the count register only: no rc_ready -> ready_out path.
   assign ready_out    = (r_count != FULL);
   assign valid_out    = (r_count != '0);
   assign w_push       = valid_in && ready_out;
   assign w_pop        = rc_ready && valid_out;
   assign data_out     = valid_out ? r_mem[r_rd_ptr] : '0;
   assign pressure_out = r_count;
   assign ovf_err      = r_ovf;

   always_ff @(posedge ib_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Pointers are exactly WIDTH bits, so wrap from DEPTH-1 to 0 is free.
   always_ff @(posedge ib_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + WIDTH'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + WIDTH'(1);
      end
   end

   always_ff @(posedge ib_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + PW'(1);
            2'b01:   r_count <= r_count - PW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A flit offered while full is dropped; flag it until reset, even if a pop frees space.
   always_ff @(posedge ib_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (valid_in && !ready_out) begin
         r_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ib_sub.sv
// Scoreboard bench for ib_sub: accepted flits are queued, popped flits compared in order.
module tb_ib_sub;

   localparam int DEPTH = 8;
   localparam int WIDTH = 3;
   localparam int DS    = 40;

   logic          ib_clk = 1'b0;
   logic          rst_n  = 1'b0;
   logic [DS-1:0] data_in  = '0;
   logic          valid_in = 1'b0;
   logic          ready_out;
   logic [DS-1:0] data_out;
   logic          valid_out;
   logic          rc_ready = 1'b0;
   logic [WIDTH:0] pressure_out;
   logic          ovf_err;

   int n_chk = 0;
   int n_err = 0;
   logic [DS-1:0] sb_q[$];

   ib_sub #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DS)) dut (
      .ib_clk(ib_clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
      .rc_ready(rc_ready), .pressure_out(pressure_out), .ovf_err(ovf_err)
   );

   always #5 ib_clk = ~ib_clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ib_clk);
      #1;
   endtask

   // Inputs change 1ns after posedge, so at negedge they describe the coming edge.
   always @(negedge ib_clk) begin
      if (rst_n) begin
         if (valid_out && rc_ready) begin
            if (sb_q.size() == 0) chk("pop_underflow", 64'(data_out), 64'hFFFF_FFFF_FFFF_FFFF);
            else                  chk("pop_data", 64'(data_out), 64'(sb_q.pop_front()));
         end
         if (valid_in && ready_out) sb_q.push_back(data_in);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      chk("rst_ready",    64'(ready_out),    64'd1);
      chk("rst_valid",    64'(valid_out),    64'd0);
      chk("rst_data",     64'(data_out),     64'd0);
      chk("rst_pressure", 64'(pressure_out), 64'd0);
      chk("rst_ovf",      64'(ovf_err),      64'd0);
      @(posedge ib_clk); #3; rst_n = 1'b1;
      tick();

      // Fill to full, no consumption
      for (int i = 0; i < DEPTH; i++) begin
         valid_in = 1'b1;
         data_in  = 40'(i + 1) << 32;
         tick();
         chk("fill_pressure", 64'(pressure_out), 64'(i + 1));
         chk("fill_valid",    64'(valid_out),    64'd1);
      end
      valid_in = 1'b0;
      chk("full_ready", 64'(ready_out), 64'd0);
      chk("full_head",  64'(data_out),  64'h1_0000_0000);

      // Overflow: offer one flit while full
      valid_in = 1'b1; data_in = 40'hDEAD;
      tick();
      valid_in = 1'b0; data_in = '0;
      chk("ovf_set",      64'(ovf_err),      64'd1);
      chk("ovf_pressure", 64'(pressure_out), 64'd8);
      tick();
      chk("ovf_sticky",   64'(ovf_err),      64'd1);

      // Drain in order
      rc_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk("drain_pressure", 64'(pressure_out), 64'(DEPTH - 1 - i));
      end
      rc_ready = 1'b0;
      chk("drain_valid", 64'(valid_out), 64'd0);
      chk("drain_data",  64'(data_out),  64'd0);
      chk("drain_sb",    64'(sb_q.size()), 64'd0);
      chk("ovf_still",   64'(ovf_err),   64'd1);

      // Full with simultaneous pop and valid_in: push refused, count drops
      for (int i = 0; i < DEPTH; i++) begin
         valid_in = 1'b1; data_in = 40'h20_0000_0000 + 40'(i); tick();
      end
      rc_ready = 1'b1; valid_in = 1'b1; data_in = 40'hBEEF;
      tick();
      valid_in = 1'b0;
      chk("fullpop_pressure", 64'(pressure_out), 64'd7);
      for (int i = 0; i < DEPTH - 1; i++) tick();
      rc_ready = 1'b0;
      chk("fullpop_empty", 64'(pressure_out), 64'd0);

      // Simultaneous push/pop at count=3, wrapping the pointers
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1; data_in = 40'h30_0000_0000 + 40'(i); tick();
      end
      rc_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data_in = {$urandom(), 8'(i)};
         tick();
         chk("pp_pressure", 64'(pressure_out), 64'd3);
      end
      valid_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rc_ready = 1'b0;
      chk("pp_drained", 64'(pressure_out), 64'd0);
      chk("pp_sb",      64'(sb_q.size()),  64'd0);

      // Empty with rc_ready: no fall-through
      rc_ready = 1'b1;
      tick();
      chk("empty_valid_pre", 64'(valid_out), 64'd0);
      valid_in = 1'b1; data_in = 40'h0_1000_0004;
      #2;
      chk("empty_nofall", 64'(valid_out), 64'd0);
      tick();
      valid_in = 1'b0; data_in = '0;
      chk("empty_valid_post", 64'(valid_out), 64'd1);
      chk("empty_data_post",  64'(data_out),  64'h0_1000_0004);
      tick();
      chk("empty_popped", 64'(valid_out), 64'd0);
      rc_ready = 1'b0;

      // Asynchronous reset mid-stream at count=5
      for (int i = 0; i < 5; i++) begin
         valid_in = 1'b1; data_in = 40'h50_0000_0000 + 40'(i); tick();
      end
      valid_in = 1'b0;
      chk("pre_rst_pressure", 64'(pressure_out), 64'd5);
      #2; rst_n = 1'b0; #1;
      sb_q.delete();
      chk("arst_pressure", 64'(pressure_out), 64'd0);
      chk("arst_valid",    64'(valid_out),    64'd0);
      chk("arst_data",     64'(data_out),     64'd0);
      chk("arst_ready",    64'(ready_out),    64'd1);
      chk("arst_ovf",      64'(ovf_err),      64'd0);
      #2; rst_n = 1'b1;
      tick();

      // Post-reset sanity: stale flits are gone, new ones flow
      valid_in = 1'b1; data_in = 40'h7_0000_0077; tick();
      valid_in = 1'b0; rc_ready = 1'b1; tick();
      rc_ready = 1'b0;
      chk("post_rst_empty", 64'(pressure_out), 64'd0);
      chk("post_rst_sb",    64'(sb_q.size()),  64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
